// File: rtl/shift_chain_pkg.sv
// Shared types and elaboration helpers for the shift-chain sequencer.
// The FSM state encoding and the derived sizes live here.
package shift_chain_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Number of load/read-back words needed to cover the whole chain.
  function automatic int calc_nwords(input int chain_len, input int width);
    return (chain_len + width - 1) / width;
  endfunction

  // Counter width that can hold every value from 0 to max_val inclusive.
  function automatic int calc_cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/shift_chain_serdes.sv
// Parallel-to-serial load buffer feeding the chain head, plus the
// serial-to-parallel capture buffer that assembles read-back words.
module shift_chain_serdes #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clock0,
  input  logic             reset_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic [IDX_W-1:0] bit_idx,
  input  logic             word_last,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] load_buf;
  logic [WIDTH-1:0] cap_buf;
  logic [WIDTH-1:0] cap_next;

  // NOTE: the default assignment comes first so this block never infers a latch.
  always_comb begin
    cap_next          = cap_buf;
    cap_next[bit_idx] = ser_in;
  end

  // NOTE: the data buffers are reset as well, so chain_shift_in and rd_data
  // come out of reset at a defined 0 rather than whatever powered up.
  always_ff @(posedge clock0) begin
    if (!reset_n) begin
      load_buf <= '0;
      cap_buf  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (load_en) begin
        load_buf <= load_data;
        // Clearing here zero-pads a short final word in its upper bits.
        cap_buf  <= '0;
      end else if (shift_en) begin
        load_buf <= load_buf >> 1;
        cap_buf  <= cap_next;
        if (word_last) begin
          rd_valid <= 1'b1;
          rd_data  <= cap_next;
        end
      end
    end
  end

  assign ser_out = load_buf[0];

endmodule

// File: rtl/shift_chain_ctrl.sv
// Sequencer that writes a whole serial chain from parallel load words and
// returns the chain's previous contents as parallel read-back words.
module shift_chain_ctrl
  import shift_chain_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHAIN_LEN = 12
) (
  input  logic             clock0,
  input  logic             reset_n,
  input  logic             start,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             chain_shift_en,
  output logic             chain_shift_in,
  input  logic             chain_shift_out,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done
);

  localparam int NWORDS = calc_nwords(CHAIN_LEN, WIDTH);
  localparam int CNT_W  = calc_cnt_w(CHAIN_LEN);
  localparam int WC_W   = calc_cnt_w(NWORDS);
  localparam int NB_W   = calc_cnt_w(WIDTH);
  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (CHAIN_LEN < 1) begin : g_bad_chain_len
    $error("shift_chain_ctrl: CHAIN_LEN must be at least 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("shift_chain_ctrl: WIDTH must be at least 1");
  end

  state_t           state;
  logic [CNT_W-1:0] bits_done;
  logic [WC_W-1:0]  word_cnt;
  logic [NB_W-1:0]  bit_idx;
  logic [NB_W-1:0]  nbits;
  logic [NB_W-1:0]  nbits_next;
  logic             fire;
  logic             word_last;
  logic             chain_last;

  assign fire       = load_ready && load_valid;
  assign word_last  = chain_shift_en && ((bit_idx + NB_W'(1)) == nbits);
  assign chain_last = (int'(bits_done) + 1) == CHAIN_LEN;
  // At a word boundary word_cnt*WIDTH equals bits_done, so this is the
  // number of bits still owed to the chain, capped at one word.
  assign nbits_next = NB_W'(min_int(WIDTH, CHAIN_LEN - int'(word_cnt) * WIDTH));

  // NOTE: every state update is non-blocking so all flops see pre-edge values.
  always_ff @(posedge clock0) begin
    if (!reset_n) begin
      state          <= IDLE;
      load_ready     <= 1'b0;
      chain_shift_en <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bits_done      <= '0;
      word_cnt       <= '0;
      bit_idx        <= '0;
      nbits          <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= FETCH;
            load_ready <= 1'b1;
            busy       <= 1'b1;
            bits_done  <= '0;
            word_cnt   <= '0;
            bit_idx    <= '0;
          end
        end
        FETCH: begin
          if (fire) begin
            state          <= SHIFT;
            load_ready     <= 1'b0;
            chain_shift_en <= 1'b1;
            nbits          <= nbits_next;
            bit_idx        <= '0;
          end
        end
        SHIFT: begin
          bits_done <= bits_done + CNT_W'(1);
          bit_idx   <= bit_idx + NB_W'(1);
          if (word_last) begin
            chain_shift_en <= 1'b0;
            word_cnt       <= word_cnt + WC_W'(1);
            if (chain_last) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state      <= FETCH;
              load_ready <= 1'b1;
            end
          end
        end
        FINISH: begin
          // A start seen here is dropped; only IDLE samples it.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  shift_chain_serdes #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_serdes (
    .clock0    (clock0),
    .reset_n   (reset_n),
    .load_en   (fire),
    .load_data (load_data),
    .shift_en  (chain_shift_en),
    .bit_idx   (bit_idx[IDX_W-1:0]),
    .word_last (word_last),
    .ser_in    (chain_shift_out),
    .ser_out   (chain_shift_in),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

  a_en_only_in_shift: assert property (@(posedge clock0) disable iff (!reset_n)
    chain_shift_en |-> state == SHIFT);
  a_ready_only_in_fetch: assert property (@(posedge clock0) disable iff (!reset_n)
    load_ready |-> state == FETCH);
  a_done_only_in_finish: assert property (@(posedge clock0) disable iff (!reset_n)
    done |-> state == FINISH);

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Self-checking bench for shift_chain_ctrl: a behavioural 12-flop chain plus
// a read-back scoreboard filled from the chain model before each operation.
module tb_shift_chain_ctrl;

  localparam int WIDTH     = 8;
  localparam int CHAIN_LEN = 12;
  localparam int NWORDS    = 2;

  logic             clock0 = 1'b0;
  logic             reset_n;
  logic             start;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             chain_shift_en;
  logic             chain_shift_in;
  logic             chain_shift_out;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;

  logic [CHAIN_LEN-1:0] chain = '0;
  logic [WIDTH-1:0]     rd_q[$];

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  always #5 clock0 = ~clock0;

  shift_chain_ctrl #(
    .WIDTH     (WIDTH),
    .CHAIN_LEN (CHAIN_LEN)
  ) dut (
    .clock0          (clock0),
    .reset_n         (reset_n),
    .start           (start),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_data       (load_data),
    .chain_shift_en  (chain_shift_en),
    .chain_shift_in  (chain_shift_in),
    .chain_shift_out (chain_shift_out),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .busy            (busy),
    .done            (done)
  );

  // Head is flop 0, tail is flop CHAIN_LEN-1.
  always @(posedge clock0) if (chain_shift_en) chain <= {chain[CHAIN_LEN-2:0], chain_shift_in};
  assign chain_shift_out = chain[CHAIN_LEN-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock0) begin
    if (chain_shift_en === 1'b1) en_cnt++;
    if (done === 1'b1) done_cnt++;
    if (rd_valid === 1'b1) begin
      rd_cnt++;
      if (rd_q.size() == 0) check("rd_extra", 1, 0);
      else check("rd_data", rd_data, rd_q.pop_front());
    end
  end

  // One full operation; stall holds off the second word, poke pulses start
  // during SHIFT and again during FINISH.
  task automatic run_op(input logic [7:0] w0, input logic [7:0] w1,
                        input int stall, input bit poke);
    logic [WIDTH-1:0]     words[NWORDS];
    logic [WIDTH-1:0]     exp_w;
    logic [WIDTH-1:0]     rev;
    logic [CHAIN_LEN-1:0] exp_chain;
    int n, widx, wait_cnt, lat, en0, rd0, dn0;
    bit got_done;
    words[0] = w0;
    words[1] = w1;
    for (int w = 0; w < NWORDS; w++) begin
      exp_w = '0;
      for (int b = 0; b < WIDTH; b++)
        if (w * WIDTH + b < CHAIN_LEN) exp_w[b] = chain[CHAIN_LEN-1-(w*WIDTH+b)];
      rd_q.push_back(exp_w);
    end
    exp_chain = '0;
    for (int k = 0; k < CHAIN_LEN; k++) exp_chain[CHAIN_LEN-1-k] = words[k/WIDTH][k%WIDTH];
    for (int b = 0; b < WIDTH; b++) rev[WIDTH-1-b] = w0[b];

    @(posedge clock0);
    en0 = en_cnt; rd0 = rd_cnt; dn0 = done_cnt;
    @(negedge clock0); start = 1'b1;
    @(negedge clock0); start = 1'b0;
    n = 1; widx = 0; wait_cnt = 0; got_done = 1'b0; lat = 0;
    while (!got_done && n < 200) begin
      load_valid = 1'b0;
      if (done) begin
        got_done = 1'b1;
        lat = n + 1;
      end else begin
        if (load_ready && widx < NWORDS) begin
          if (widx == 1 && wait_cnt < stall) begin
            wait_cnt++;
            check("stall_en", chain_shift_en, 0);
            check("stall_chain", chain[WIDTH-1:0], rev);
          end else begin
            load_valid = 1'b1;
            load_data  = words[widx];
            widx++;
          end
        end
        start = (poke && n == 5);
        @(negedge clock0);
        n++;
      end
    end
    check("done_seen", got_done, 1);
    if (!got_done) rd_q.delete();
    check("latency", lat, 16 + stall);
    if (poke) start = 1'b1;
    @(negedge clock0);
    start = 1'b0;
    check("done_width", done, 0);
    check("idle_busy", busy, 0);
    @(negedge clock0);
    check("stay_idle", busy, 0);
    @(posedge clock0);
    check("en_cycles", en_cnt - en0, CHAIN_LEN);
    check("rd_pulses", rd_cnt - rd0, NWORDS);
    check("done_pulses", done_cnt - dn0, 1);
    check("rd_q_empty", rd_q.size(), 0);
    check("chain", chain, exp_chain);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en0, rd0, dn0, n, seen;
    reset_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = '0;
    repeat (3) @(negedge clock0);
    check("rst_load_ready", load_ready, 0);
    check("rst_shift_en", chain_shift_en, 0);
    check("rst_shift_in", chain_shift_in, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset_n = 1'b1;

    // Start with no load data: parks in FETCH with the chain idle.
    @(posedge clock0); en0 = en_cnt;
    @(negedge clock0); start = 1'b1;
    @(negedge clock0); start = 1'b0;
    repeat (10) @(negedge clock0);
    check("fetch_ready", load_ready, 1);
    check("fetch_busy", busy, 1);
    check("fetch_en", chain_shift_en, 0);
    @(posedge clock0);
    check("fetch_no_shift", en_cnt - en0, 0);
    @(negedge clock0); reset_n = 1'b0;
    @(negedge clock0);
    check("fetch_rst_busy", busy, 0);
    check("fetch_rst_ready", load_ready, 0);
    reset_n = 1'b1;

    run_op(8'hA5, 8'h03, 0, 1'b0);
    check("op1_chain", chain, 12'hA5C);
    run_op(8'h00, 8'h00, 0, 1'b0);
    check("op2_chain", chain, 12'h000);
    run_op(8'hA5, 8'h03, 5, 1'b0);
    check("stall_chain_final", chain, 12'hA5C);
    run_op(8'h00, 8'h00, 0, 1'b1);

    // Abort after four enabled shift edges of an all-ones word.
    @(posedge clock0);
    en0 = en_cnt; rd0 = rd_cnt; dn0 = done_cnt;
    @(negedge clock0); start = 1'b1;
    @(negedge clock0); start = 1'b0;
    n = 0; seen = 0;
    while (seen < 4 && n < 50) begin
      load_valid = load_ready;
      load_data  = 8'hFF;
      if (chain_shift_en) seen++;
      if (seen < 4) begin
        @(negedge clock0);
        n++;
      end
    end
    check("abort_reached", seen, 4);
    load_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clock0);
    check("abort_busy", busy, 0);
    check("abort_en", chain_shift_en, 0);
    check("abort_ready", load_ready, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock0);
    @(posedge clock0);
    check("abort_no_done", done_cnt - dn0, 0);
    check("abort_no_rd", rd_cnt - rd0, 0);
    check("abort_shifts", en_cnt - en0, 4);
    check("abort_chain", chain, 12'h00F);

    run_op(8'hFF, 8'h0F, 0, 1'b0);
    check("final_chain", chain, 12'hFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
